// File: rtl/lcd_text_driver.sv
// HD44780 line-1 text driver: power-on init, then paints 16 ROM characters and
// re-paints whenever the latched mode goes stale or a refresh is requested.
module lcd_text_driver #(
   parameter int T_POWER = 750000,
   parameter int T_SETUP = 4,
   parameter int T_PW    = 25,
   parameter int T_GAP   = 2500,
   parameter int T_CLR   = 100000
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] mode,
   input  logic       refresh,
   output logic [1:0] rom_mode,
   output logic [3:0] char_idx,
   input  logic [7:0] char_data,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_PWR_WAIT, S_FUNC, S_DISP, S_ENTRY, S_CLR, S_HOME, S_WRITE, S_IDLE
   } state_t;

   typedef enum logic [1:0] {PH_LOAD, PH_SETUP, PH_PULSE, PH_GAP} phase_t;

   // Reload values are one less than the cycle count; the power wait spends
   // its first cycle loading the counter, hence the extra minus one.
   localparam logic [31:0] C_POWER = 32'(T_POWER - 2);
   localparam logic [31:0] C_SETUP = 32'(T_SETUP - 1);
   localparam logic [31:0] C_PW    = 32'(T_PW - 1);
   localparam logic [31:0] C_GAP   = 32'(T_GAP - 1);
   localparam logic [31:0] C_CLR   = 32'(T_CLR - 1);

   state_t      r_state, w_state_nxt;
   phase_t      r_phase, w_phase_nxt;
   logic [31:0] r_cnt,   w_cnt_nxt;
   logic        r_e,     w_e_nxt;
   logic        r_rs,    w_rs_nxt;
   logic [7:0]  r_data,  w_data_nxt;
   logic [3:0]  r_idx,   w_idx_nxt;
   logic [1:0]  r_rom_mode, w_rom_mode_nxt;
   logic        r_busy,  w_busy_nxt;

   logic        w_start;
   state_t      w_start_state;
   logic        w_start_rs;
   logic [7:0]  w_start_data;

   // Next-state and next-output logic for the sequencer and transaction timer.
   always_comb begin
      w_state_nxt    = r_state;
      w_phase_nxt    = r_phase;
      w_cnt_nxt      = r_cnt;
      w_e_nxt        = r_e;
      w_rs_nxt       = r_rs;
      w_data_nxt     = r_data;
      w_idx_nxt      = r_idx;
      w_rom_mode_nxt = r_rom_mode;
      w_busy_nxt     = r_busy;
      w_start        = 1'b0;
      w_start_state  = r_state;
      w_start_rs     = 1'b0;
      w_start_data   = 8'h00;

      case (r_state)
         S_PWR_WAIT: begin
            if (r_phase == PH_LOAD) begin
               w_cnt_nxt   = C_POWER;
               w_phase_nxt = PH_GAP;
            end else if (r_cnt == 32'd0) begin
               w_start       = 1'b1;
               w_start_state = S_FUNC;
               w_start_data  = 8'h38;
            end else begin
               w_cnt_nxt = r_cnt - 32'd1;
            end
         end
         S_IDLE: begin
            if ((mode != r_rom_mode) || refresh) begin
               w_start        = 1'b1;
               w_start_state  = S_HOME;
               w_start_data   = 8'h80;
               w_rom_mode_nxt = mode;
               w_idx_nxt      = 4'd0;
            end else begin
               w_e_nxt = 1'b0;
            end
         end
         default: begin
            case (r_phase)
               PH_SETUP: begin
                  if (r_cnt == 32'd0) begin
                     w_phase_nxt = PH_PULSE;
                     w_e_nxt     = 1'b1;
                     w_cnt_nxt   = C_PW;
                  end else begin
                     w_cnt_nxt = r_cnt - 32'd1;
                  end
               end
               PH_PULSE: begin
                  if (r_cnt == 32'd0) begin
                     w_phase_nxt = PH_GAP;
                     w_e_nxt     = 1'b0;
                     w_cnt_nxt   = (r_state == S_CLR) ? C_CLR : C_GAP;
                  end else begin
                     w_cnt_nxt = r_cnt - 32'd1;
                  end
               end
               PH_GAP: begin
                  // Advance the index one cycle early so the combinational ROM
                  // already shows the next byte on the edge that starts its write.
                  if ((r_state == S_WRITE) && (r_cnt == 32'd1)) begin
                     w_idx_nxt = r_idx + 4'd1;
                  end else begin
                     w_idx_nxt = r_idx;
                  end
                  if (r_cnt == 32'd0) begin
                     case (r_state)
                        S_FUNC: begin
                           w_start       = 1'b1;
                           w_start_state = S_DISP;
                           w_start_data  = 8'h0C;
                        end
                        S_DISP: begin
                           w_start       = 1'b1;
                           w_start_state = S_ENTRY;
                           w_start_data  = 8'h06;
                        end
                        S_ENTRY: begin
                           w_start       = 1'b1;
                           w_start_state = S_CLR;
                           w_start_data  = 8'h01;
                        end
                        S_CLR: begin
                           w_start        = 1'b1;
                           w_start_state  = S_HOME;
                           w_start_data   = 8'h80;
                           w_rom_mode_nxt = mode;
                           w_idx_nxt      = 4'd0;
                        end
                        S_HOME: begin
                           w_start       = 1'b1;
                           w_start_state = S_WRITE;
                           w_start_rs    = 1'b1;
                           w_start_data  = char_data;
                        end
                        S_WRITE: begin
                           // Index wrapped back to 0: position 15 was the last write.
                           if (r_idx == 4'd0) begin
                              w_state_nxt = S_IDLE;
                              w_phase_nxt = PH_LOAD;
                           end else begin
                              w_start       = 1'b1;
                              w_start_state = S_WRITE;
                              w_start_rs    = 1'b1;
                              w_start_data  = char_data;
                           end
                        end
                        default: begin
                           w_state_nxt = S_PWR_WAIT;
                           w_phase_nxt = PH_LOAD;
                        end
                     endcase
                  end else begin
                     w_cnt_nxt = r_cnt - 32'd1;
                  end
               end
               default: begin
                  w_phase_nxt = PH_SETUP;
                  w_cnt_nxt   = C_SETUP;
               end
            endcase
         end
      endcase

      if (w_start) begin
         w_state_nxt = w_start_state;
         w_phase_nxt = PH_SETUP;
         w_cnt_nxt   = C_SETUP;
         w_e_nxt     = 1'b0;
         w_rs_nxt    = w_start_rs;
         w_data_nxt  = w_start_data;
         w_busy_nxt  = 1'b1;
      end else begin
         w_busy_nxt = (w_state_nxt != S_IDLE);
      end
   end

   // State, timer and registered LCD/ROM outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_PWR_WAIT;
         r_phase    <= PH_LOAD;
         r_cnt      <= 32'd0;
         r_e        <= 1'b0;
         r_rs       <= 1'b0;
         r_data     <= 8'h00;
         r_idx      <= 4'd0;
         r_rom_mode <= 2'b00;
         r_busy     <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_phase    <= w_phase_nxt;
         r_cnt      <= w_cnt_nxt;
         r_e        <= w_e_nxt;
         r_rs       <= w_rs_nxt;
         r_data     <= w_data_nxt;
         r_idx      <= w_idx_nxt;
         r_rom_mode <= w_rom_mode_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   assign lcd_e    = r_e;
   assign lcd_rs   = r_rs;
   assign lcd_rw   = 1'b0;
   assign lcd_data = r_data;
   assign char_idx = r_idx;
   assign rom_mode = r_rom_mode;
   assign busy     = r_busy;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Scoreboard bench for lcd_text_driver: expected LCD transactions are queued by
// the stimulus and checked by a monitor on every E pulse.
module tb_lcd_text_driver;
   localparam int TP = 20;
   localparam int TS = 2;
   localparam int TW = 4;
   localparam int TG = 8;
   localparam int TC = 40;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] mode;
   logic       refresh;
   logic [1:0] rom_mode;
   logic [3:0] char_idx;
   logic [7:0] char_data;
   logic       lcd_e, lcd_rs, lcd_rw, busy;
   logic [7:0] lcd_data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      logic [3:0] idx;
      int         low;
   } exp_t;
   exp_t sb[$];
   exp_t ex;

   logic [7:0] watch_hex [16] = '{8'h4D, 8'h4F, 8'h44, 8'h45, 8'h31, 8'h3A, 8'h20, 8'h57,
                                  8'h41, 8'h54, 8'h43, 8'h48, 8'h20, 8'h20, 8'h20, 8'h20};

   lcd_text_driver #(.T_POWER(TP), .T_SETUP(TS), .T_PW(TW), .T_GAP(TG), .T_CLR(TC)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .refresh(refresh),
      .rom_mode(rom_mode), .char_idx(char_idx), .char_data(char_data),
      .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] line_of(input logic [1:0] m);
      case (m)
         2'b00:   line_of = "MODE1: WATCH    ";
         2'b01:   line_of = "MODE2: ALARM    ";
         2'b10:   line_of = "MODE3: STOP     ";
         default: line_of = "MODE4: SET      ";
      endcase
   endfunction

   function automatic logic [7:0] rom_char(input logic [1:0] m, input logic [3:0] i);
      logic [127:0] l;
      int ii;
      l  = line_of(m);
      ii = int'(i);
      rom_char = l[127 - 8*ii -: 8];
   endfunction

   assign char_data = rom_char(rom_mode, char_idx);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, expv, cyc);
      end
   endtask

   task automatic push(input logic rs, input logic [7:0] d, input logic [3:0] i, input int low);
      exp_t e;
      e.rs = rs; e.data = d; e.idx = i; e.low = low;
      sb.push_back(e);
   endtask

   task automatic push_line(input logic [1:0] m, input int first_low);
      push(1'b0, 8'h80, 4'd0, first_low);
      for (int i = 0; i < 16; i++) begin
         push(1'b1, (m == 2'b00) ? watch_hex[i] : rom_char(m, 4'(i)), 4'(i), TG + TS);
      end
   endtask

   task automatic push_init(input logic [1:0] m);
      push(1'b0, 8'h38, 4'd0, TP + TS);
      push(1'b0, 8'h0C, 4'd0, TG + TS);
      push(1'b0, 8'h06, 4'd0, TG + TS);
      push(1'b0, 8'h01, 4'd0, TG + TS);
      push_line(m, TC + TS);
   endtask

   task automatic wait_busy(input logic lvl, input int max, output int n);
      n = 0;
      while (busy !== lvl && n < max) begin
         @(negedge clk);
         n++;
      end
      check("busy_wait", {31'd0, busy}, {31'd0, lvl});
   endtask

   // Monitor: pops one expectation per E pulse and checks timing and content.
   logic e_prev;
   int   rise_cyc, fall_cyc;
   logic [7:0] hold_data;
   logic hold_rs;
   logic stable_ok;
   always @(negedge clk) begin
      if (!rst_n) begin
         e_prev   = 1'b0;
         fall_cyc = cyc;
      end else begin
         if (lcd_e && !e_prev) begin
            rise_cyc  = cyc;
            hold_data = lcd_data;
            hold_rs   = lcd_rs;
            stable_ok = 1'b1;
            if (sb.size() == 0) begin
               check("unexpected_pulse", {23'd0, lcd_rs, lcd_data}, 32'hFFFF_FFFF);
            end else begin
               ex = sb.pop_front();
               check("lcd_rs", {31'd0, lcd_rs}, {31'd0, ex.rs});
               check("lcd_data", {24'd0, lcd_data}, {24'd0, ex.data});
               check("lcd_rw", {31'd0, lcd_rw}, 32'd0);
               if (ex.rs) check("char_idx", {28'd0, char_idx}, {28'd0, ex.idx});
               if (ex.low >= 0) check("e_low_cycles", rise_cyc - fall_cyc, ex.low);
            end
         end else if (lcd_e && e_prev) begin
            if (lcd_data !== hold_data || lcd_rs !== hold_rs) stable_ok = 1'b0;
         end else if (!lcd_e && e_prev) begin
            fall_cyc = cyc;
            check("e_high_cycles", cyc - rise_cyc, TW);
            check("stable_while_e", {31'd0, stable_ok}, 32'd1);
         end
         e_prev = lcd_e;
      end
   end

   int n, c0, t0;

   initial begin
      rst_n = 1'b0; mode = 2'b00; refresh = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_e", {31'd0, lcd_e}, 32'd0);
      check("rst_rs", {31'd0, lcd_rs}, 32'd0);
      check("rst_data", {24'd0, lcd_data}, 32'd0);
      check("rst_idx", {28'd0, char_idx}, 32'd0);
      check("rst_rom_mode", {30'd0, rom_mode}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd1);

      // Power-on init and first paint.
      push_init(2'b00);
      @(negedge clk); #1 rst_n = 1'b1; c0 = cyc;
      wait_busy(1'b0, 500, n);
      check("init_busy_cycles", cyc - c0, 346);
      check("init_queue_empty", sb.size(), 0);
      check("idle_idx", {28'd0, char_idx}, 32'd0);

      // Mode change in IDLE: HOME + 16 writes, no clear.
      @(negedge clk);
      push_line(2'b10, -1);
      mode = 2'b10;
      wait_busy(1'b1, 5, n);
      t0 = cyc;
      wait_busy(1'b0, 400, n);
      check("repaint_busy_cycles", cyc - t0, 238);
      check("rom_mode_stop", {30'd0, rom_mode}, 32'd2);
      check("stop_queue_empty", sb.size(), 0);

      // Mode change mid-paint: ALARM completes, then SET follows at once.
      push_line(2'b01, -1);
      mode = 2'b01;
      wait_busy(1'b1, 5, n);
      n = 0;
      while (!(lcd_rs === 1'b1 && char_idx === 4'd5) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("reach_idx5", {28'd0, char_idx}, 32'd5);
      mode = 2'b11;
      push_line(2'b11, TG + 1 + TS);
      wait_busy(1'b0, 400, n);
      check("alarm_rom_mode_held", {30'd0, rom_mode}, 32'd1);
      wait_busy(1'b1, 5, n);
      check("repaint_next_cycle", n, 1);
      wait_busy(1'b0, 400, n);
      check("rom_mode_set", {30'd0, rom_mode}, 32'd3);
      check("set_queue_empty", sb.size(), 0);

      // Refresh in IDLE repaints; a refresh while busy is dropped.
      @(negedge clk);
      push_line(2'b11, -1);
      refresh = 1'b1;
      @(negedge clk); refresh = 1'b0;
      wait_busy(1'b1, 3, n);
      repeat (50) @(negedge clk);
      refresh = 1'b1;
      @(negedge clk); refresh = 1'b0;
      wait_busy(1'b0, 400, n);
      repeat (300) @(negedge clk);
      check("no_extra_repaint_busy", {31'd0, busy}, 32'd0);
      check("refresh_queue_empty", sb.size(), 0);

      // Mode change and refresh together: exactly one repaint.
      push_line(2'b00, -1);
      mode = 2'b00; refresh = 1'b1;
      @(negedge clk); refresh = 1'b0;
      wait_busy(1'b1, 3, n);
      wait_busy(1'b0, 400, n);
      repeat (300) @(negedge clk);
      check("single_repaint_busy", {31'd0, busy}, 32'd0);
      check("single_queue_empty", sb.size(), 0);

      // Reset while E is high, then full init again.
      push_line(2'b00, -1);
      refresh = 1'b1;
      @(negedge clk); refresh = 1'b0;
      n = 0;
      while (lcd_e !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("e_high_before_reset", {31'd0, lcd_e}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_e", {31'd0, lcd_e}, 32'd0);
      check("midrst_rs", {31'd0, lcd_rs}, 32'd0);
      check("midrst_data", {24'd0, lcd_data}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd1);
      sb.delete();
      repeat (3) @(negedge clk);
      push_init(2'b00);
      #1 rst_n = 1'b1; c0 = cyc;
      wait_busy(1'b0, 500, n);
      check("reinit_busy_cycles", cyc - c0, 346);
      check("reinit_queue_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
